uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver, the downstream counterpart of the UART transmitter: consumes the 8N1-style serial line that transmitter drives and delivers each received word on a one-entry valid/ready output. Synchronises the asynchronous line, validates the start bit at mid-bit, samples data bits LSB first at bit centres, checks the stop bit, and flags framing and overrun errors.

## Interface
- CLK_FREQUENCY, default 100_000_000: clock frequency in Hz.
- BAUD_RATE, default 115_200: line rate in bit/s; DIV = CLK_FREQUENCY/BAUD_RATE (integer division, must be ≥ 4), HALF = DIV/2.
- DATA_BITS, default 8: data bits per frame, LSB first; 1 start bit, 1 stop bit, no parity.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- serial_in  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  received word, stable while rx_valid = 1; reset 0.
- rx_valid  out  1  holding register full; reset 0.
- rx_ready  in  1  consumer accepts data_out when rx_valid & rx_ready.
- rx_busy  out  1  high in START/DATA/STOP; reset 0.
- framing_error  out  1  one-cycle pulse, stop bit sampled 0; reset 0.
- overrun_error  out  1  one-cycle pulse, good frame dropped because the holding register was full; reset 0.

## Operation
- Two-flop synchroniser on serial_in, both flops reset to 1; all logic uses the synchronised line `rxs`.
- Baud counter, width $clog2(DIV), cleared on every state entry.
- States: IDLE, START, DATA, STOP.
- IDLE: armed only once rxs has been sampled 1 since the last frame or reset (break/stuck-low protection). Armed and rxs = 0 → START.
- START: at counter == HALF-1, sample rxs. If 1 → IDLE (false start, no flags). If 0 → DATA, bit index 0.
- DATA: at counter == DIV-1, shift rxs into bit [index]; after index DATA_BITS-1 → STOP.
- STOP: at counter == DIV-1, sample rxs. If 1: good frame. If 0: framing_error pulse, frame discarded, IDLE disarmed until rxs = 1. Either way → IDLE.
- Good frame: if rx_valid = 0, or rx_valid & rx_ready in the same cycle, load data_out and set rx_valid. Otherwise keep the old data_out and rx_valid, and pulse overrun_error.
- rx_valid clears on rx_valid & rx_ready unless a new word loads in that same cycle.
- Reset mid-frame: all state cleared immediately, state IDLE, unarmed until rxs = 1. Any partial frame is lost.

## Timing
- Let T be the first cycle rxs = 0 in armed IDLE. The pin falling edge reaches rxs 2 cycles after it is launched.
- START is entered at T+1. Start is sampled at T+HALF.
- Data bit k is sampled at T+HALF+(k+1)·DIV.
- Stop bit is sampled at S = T+HALF+(DATA_BITS+1)·DIV.
- rx_valid, or framing_error / overrun_error, asserts at cycle S+1. rx_busy falls at S+1.
- Back-to-back frames are supported: a new start edge is detected from S+1 onward. The mid-stop sample leaves at least HALF cycles of margin.
- Sampling point drift must stay within ±HALF over a frame: tolerated clock mismatch ≈ ±(HALF/DIV)/(DATA_BITS+1.5).

## Structure
- Package uart_pkg:
  - uart_rx_state enum (IDLE, START, DATA, STOP), logic [1:0].
  - Constant function for the baud divider, shared with the transmitter.
- Sub-module uart_sync: parameterised N-flop synchroniser with reset value parameter, async active-low reset. Instantiated with N = 2, reset value 1.
- The baud counter, bit index, shift register and output holding register live in uart_rx.

## Test plan
Bench parameters: CLK_FREQUENCY 1_600_000, BAUD_RATE 100_000 (DIV 16), DATA_BITS 8.
- Frame 0xA5 driven at exactly 16 cycles/bit, rx_ready = 1 → data_out = 0xA5, rx_valid high one cycle at S+1, no error flags.
- Low glitch of 5 cycles on idle line → START entered, aborts at HALF, no rx_valid, rx_busy back to 0.
- Frame 0x3C with stop bit driven 0, then line held low 40 cycles, then high → framing_error single pulse, no rx_valid, no new frame while low; next frame 0x81 received correctly.
- Frames 0x11 then 0x22 back-to-back, rx_ready = 0 → first: rx_valid = 1, data_out = 0x11; second: overrun_error pulse, data_out still 0x11. Then rx_ready = 1 for one cycle → rx_valid = 0.
- Assert reset during bit 3 of a frame → all outputs 0 asynchronously, state IDLE; next full frame 0x5A received correctly.
- Loopback from the UART transmitter, same parameters, 256 random words with random rx_ready → every word received in order, zero errors, and ±3 % baud skew on the driven line still passes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider used
// by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state;

    function automatic int baud_divider(input int clk_frequency, input int baud_rate);
        return clk_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for a single asynchronous bit; N must be at least 2.
module uart_sync #(
    parameter int   N           = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= {N{RESET_VALUE}};
        end else begin
            sync_reg <= {sync_reg[N-2:0], d};
        end
    end

    assign q = sync_reg[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation at mid-bit, LSB-first data sampling at
// bit centres, stop-bit check, and a one-entry valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int DIV   = baud_divider(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rxs;

    uart_sync #(
        .N           (2),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (rxs)
    );

    uart_rx_state         state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg,   cnt_next;
    logic [IDX_W-1:0]     idx_reg,   idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg,  data_next;
    logic                 valid_reg, valid_next;
    logic                 armed_reg, armed_next;
    logic                 ferr_reg,  ferr_next;
    logic                 oerr_reg,  oerr_next;
    logic                 good_frame;
    logic                 accept;
    logic                 load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            armed_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            oerr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            armed_reg <= armed_next;
            ferr_reg  <= ferr_next;
            oerr_reg  <= oerr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        armed_next = armed_reg;
        ferr_next  = 1'b0;
        oerr_next  = 1'b0;
        good_frame = 1'b0;
        accept     = valid_reg & rx_ready;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // A line that never returned high (break) must not start a frame.
                armed_next = armed_reg | rxs;
                if (armed_reg && !rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        idx_next   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = rxs;
                    idx_next            = idx_reg + 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxs) begin
                        good_frame = 1'b1;
                    end else begin
                        ferr_next  = 1'b1;
                        armed_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A word can load into a full register only if it is drained this cycle.
        load      = good_frame & (~valid_reg | accept);
        oerr_next = good_frame & ~load;
        if (load) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
        end else if (accept) begin
            valid_next = 1'b0;
        end
    end

    assign data_out      = data_reg;
    assign rx_valid      = valid_reg;
    assign rx_busy       = (state_reg != IDLE);
    assign framing_error = ferr_reg;
    assign overrun_error = oerr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: frame timing, glitch
// rejection, framing/overrun errors, mid-frame reset and a skewed loopback.
module tb_uart_rx;

    localparam int CLK_FREQUENCY = 1_600_000;
    localparam int BAUD_RATE     = 100_000;
    localparam int DATA_BITS     = 8;
    localparam int LAT           = 155;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       framing_error;
    logic       overrun_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int valid_rises = 0, valid_cycles = 0, valid_rise_cyc = -1;
    int ferr_cnt = 0, ferr_cyc = -1;
    int oerr_cnt = 0, oerr_cyc = -1;
    int busy_rises = 0, busy_rise_cyc = -1, busy_fall_cyc = -1;
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;
    logic [7:0] rxq[$];
    logic lb_done = 1'b0;

    uart_rx #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE),
        .DATA_BITS     (DATA_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            valid_rises++;
            valid_rise_cyc = cyc;
        end
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) rxq.push_back(data_out);
        if (framing_error) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (overrun_error) begin
            oerr_cnt++;
            oerr_cyc = cyc;
        end
        if (rx_busy && !prev_busy) begin
            busy_rises++;
            busy_rise_cyc = cyc;
        end
        if (!rx_busy && prev_busy) busy_fall_cyc = cyc;
        prev_valid = rx_valid;
        prev_busy  = rx_busy;
    end

    // Drives one frame with bit edges at floor(k*p/100) cycles (p = cycles/bit x100).
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int p,
                              output int launch);
        logic [9:0] bits;
        int b_prev, b_cur;
        bits = {stop_val, d, 1'b0};
        @(posedge clk); #1;
        serial_in = bits[0];
        launch    = cyc;
        b_prev    = 0;
        for (int k = 1; k < 10; k++) begin
            b_cur = (k * p) / 100;
            repeat (b_cur - b_prev) @(posedge clk);
            #1;
            serial_in = bits[k];
            b_prev    = b_cur;
        end
        b_cur = (10 * p) / 100;
        if (b_cur - b_prev - 1 > 0) begin
            repeat (b_cur - b_prev - 1) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        serial_in = 1'b1;
        rx_ready  = 1'b1;
        @(negedge clk);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
        total++; if ({framing_error, overrun_error} !== 2'b00) begin bad++; $display("FAIL reset_errors got=%b exp=00", {framing_error, overrun_error}); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_frame();
        int l, vr0, vc0, fe0, oe0;
        rxq.delete();
        vr0 = valid_rises; vc0 = valid_cycles; fe0 = ferr_cnt; oe0 = oerr_cnt;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1600, l);
        repeat (5) @(negedge clk);
        $display("frame A5 launched at %0d, valid at %0d", l, valid_rise_cyc);
        total++; if (rxq.size() !== 1) begin bad++; $display("FAIL frame_count got=%0d exp=1", rxq.size()); end
        else begin
            total++; if (rxq[0] !== 8'hA5) begin bad++; $display("FAIL frame_data got=%h exp=a5", rxq[0]); end
        end
        total++; if (valid_rise_cyc !== l + LAT) begin bad++; $display("FAIL frame_valid_time got=%0d exp=%0d", valid_rise_cyc, l + LAT); end
        total++; if (valid_cycles - vc0 !== 1 || valid_rises - vr0 !== 1) begin bad++; $display("FAIL frame_valid_width got=%0d exp=1", valid_cycles - vc0); end
        total++; if (busy_rise_cyc !== l + 3) begin bad++; $display("FAIL frame_busy_rise got=%0d exp=%0d", busy_rise_cyc, l + 3); end
        total++; if (busy_fall_cyc !== l + LAT) begin bad++; $display("FAIL frame_busy_fall got=%0d exp=%0d", busy_fall_cyc, l + LAT); end
        total++; if (ferr_cnt - fe0 !== 0 || oerr_cnt - oe0 !== 0) begin bad++; $display("FAIL frame_errors got=%0d/%0d exp=0/0", ferr_cnt - fe0, oerr_cnt - oe0); end
    endtask

    task automatic test_glitch();
        int l, vr0, br0;
        vr0 = valid_rises; br0 = busy_rises;
        @(posedge clk); #1;
        serial_in = 1'b0;
        l = cyc;
        repeat (5) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (40) @(negedge clk);
        $display("glitch launched at %0d, busy %0d..%0d", l, busy_rise_cyc, busy_fall_cyc);
        total++; if (busy_rises - br0 !== 1 || busy_rise_cyc !== l + 3) begin bad++; $display("FAIL glitch_busy_rise got=%0d exp=%0d", busy_rise_cyc, l + 3); end
        total++; if (busy_fall_cyc !== l + 11) begin bad++; $display("FAIL glitch_busy_fall got=%0d exp=%0d", busy_fall_cyc, l + 11); end
        total++; if (valid_rises - vr0 !== 0) begin bad++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_rises - vr0); end
    endtask

    task automatic test_framing();
        int l, vr0, fe0, br0;
        vr0 = valid_rises; fe0 = ferr_cnt; br0 = busy_rises;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1600, l);
        repeat (40) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(negedge clk);
        $display("frame 3C bad stop launched at %0d, framing at %0d", l, ferr_cyc);
        total++; if (ferr_cnt - fe0 !== 1) begin bad++; $display("FAIL framing_pulses got=%0d exp=1", ferr_cnt - fe0); end
        total++; if (ferr_cyc !== l + LAT) begin bad++; $display("FAIL framing_time got=%0d exp=%0d", ferr_cyc, l + LAT); end
        total++; if (valid_rises - vr0 !== 0) begin bad++; $display("FAIL framing_no_valid got=%0d exp=0", valid_rises - vr0); end
        total++; if (busy_rises - br0 !== 1) begin bad++; $display("FAIL framing_no_restart got=%0d exp=1", busy_rises - br0); end
        rxq.delete();
        send_frame(8'h81, 1'b1, 1600, l);
        repeat (5) @(negedge clk);
        $display("frame 81 launched at %0d, valid at %0d", l, valid_rise_cyc);
        total++; if (rxq.size() !== 1 || rxq[0] !== 8'h81) begin bad++; $display("FAIL framing_recover got=%0d words exp=1 word 81", rxq.size()); end
        total++; if (valid_rise_cyc !== l + LAT) begin bad++; $display("FAIL framing_recover_time got=%0d exp=%0d", valid_rise_cyc, l + LAT); end
    endtask

    task automatic test_back_to_back();
        int l1, l2, oe0, fe0;
        oe0 = oerr_cnt; fe0 = ferr_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1600, l1);
        @(negedge clk);
        $display("frame 11 launched at %0d, valid at %0d", l1, valid_rise_cyc);
        total++; if (rx_valid !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/11", rx_valid, data_out); end
        send_frame(8'h22, 1'b1, 1600, l2);
        @(negedge clk);
        $display("frame 22 launched at %0d, overrun at %0d", l2, oerr_cyc);
        total++; if (oerr_cnt - oe0 !== 1 || oerr_cyc !== l2 + LAT) begin bad++; $display("FAIL b2b_overrun got=%0d@%0d exp=1@%0d", oerr_cnt - oe0, oerr_cyc, l2 + LAT); end
        total++; if (rx_valid !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL b2b_hold got=%b/%h exp=1/11", rx_valid, data_out); end
        total++; if (ferr_cnt - fe0 !== 0) begin bad++; $display("FAIL b2b_no_framing got=%0d exp=0", ferr_cnt - fe0); end
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", rx_valid); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        int l;
        bits = {1'b1, 8'h96, 1'b0};
        rx_ready = 1'b1;
        @(posedge clk); #1;
        serial_in = bits[0];
        for (int k = 1; k <= 4; k++) begin
            repeat (16) @(posedge clk);
            #1 serial_in = bits[k];
        end
        repeat (8) @(posedge clk);
        #3;
        total++; if (rx_busy !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL midreset_pre got=%b/%h exp=1/11", rx_busy, data_out); end
        reset = 1'b0;
        #1;
        $display("reset asserted mid-frame at cycle %0d", cyc);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", rx_busy); end
        total++; if (data_out !== 8'h00 || rx_valid !== 1'b0) begin bad++; $display("FAIL midreset_outputs got=%h/%b exp=00/0", data_out, rx_valid); end
        serial_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        rxq.delete();
        send_frame(8'h5A, 1'b1, 1600, l);
        repeat (5) @(negedge clk);
        $display("frame 5A launched at %0d, valid at %0d", l, valid_rise_cyc);
        total++; if (rxq.size() !== 1 || rxq[0] !== 8'h5A) begin bad++; $display("FAIL midreset_next got=%0d words exp=1 word 5a", rxq.size()); end
        total++; if (valid_rise_cyc !== l + LAT) begin bad++; $display("FAIL midreset_next_time got=%0d exp=%0d", valid_rise_cyc, l + LAT); end
    endtask

    task automatic test_loopback();
        logic [7:0] expq[$];
        logic [7:0] w;
        int l, p, fe0, oe0;
        fe0 = ferr_cnt; oe0 = oerr_cnt;
        rxq.delete();
        lb_done = 1'b0;
        fork
            begin
                while (!lb_done) begin
                    @(posedge clk); #1;
                    if (!lb_done) rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 256; i++) begin
            w = 8'($urandom_range(0, 255));
            p = (i % 3 == 0) ? 1600 : ((i % 3 == 1) ? 1648 : 1552);
            expq.push_back(w);
            send_frame(w, 1'b1, p, l);
        end
        lb_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (rxq.size() !== 256) begin bad++; $display("FAIL loop_count got=%0d exp=256", rxq.size()); end
        for (int i = 0; i < 256 && i < rxq.size(); i++) begin
            $display("loop word %0d: got %h exp %h", i, rxq[i], expq[i]);
            total++; if (rxq[i] !== expq[i]) begin bad++; $display("FAIL loop_word_%0d got=%h exp=%h", i, rxq[i], expq[i]); end
        end
        total++; if (ferr_cnt - fe0 !== 0 || oerr_cnt - oe0 !== 0) begin bad++; $display("FAIL loop_errors got=%0d/%0d exp=0/0", ferr_cnt - fe0, oerr_cnt - oe0); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
